zcted_interp_ctrl_nco: RTL and testbench
========================================

Name: zcted_interp_ctrl_nco

Overview:
Interpolation controller for the ZCTED symbol-timing loop: a modulo-1 decrementing NCO driven by the PI loop-filter control word v_k (Q1.15).
- On each input sample it subtracts W = W_NOM + 2·v_k from the NCO register.
- On underflow it asserts a strobe and produces the fractional interval mu. The strobe and mu are consumed by the interpolator and the zero stuffer.
- The I/Q samples pass through register-aligned with strobe/mu, so downstream sees sample, strobe and mu in the same cycle.

Parameters:
DATA_WIDTH, 16, width of v_k (Q1.15) and of the I/Q samples
NCO_WIDTH, 16, NCO register / W / mu width, unsigned Q0.NCO_WIDTH
W_NOM, 16'h8000, nominal step (0.5 = 2 samples/symbol)
W_MIN, 16'h4000, lower clamp on W
W_MAX, 16'hC000, upper clamp on W
ETA_INIT, 16'h0000, NCO register value after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  qualifies i_in/q_in; the NCO advances only when high
i_in  input  DATA_WIDTH  in-phase sample, signed
q_in  input  DATA_WIDTH  quadrature sample, signed
v_k  input  DATA_WIDTH  loop-filter control word, signed Q1.15, sampled every cycle
out_valid  output  1  registered copy of sample_valid
i_out  output  DATA_WIDTH  i_in delayed 1 cycle
q_out  output  DATA_WIDTH  q_in delayed 1 cycle
strobe  output  1  NCO underflow on this sample (interpolant due)
mu  output  NCO_WIDTH  fractional interval, unsigned Q0.16, valid when strobe=1
eta  output  NCO_WIDTH  current NCO register (debug/verification)

Behaviour:
- Reset (rst_n low, async assert, sync release):
  - eta = ETA_INIT.
  - out_valid, strobe, mu, i_out and q_out are 0.
  - Reset mid-operation discards any pending state. The first sample_valid after release behaves exactly as after power-up.
- Step computation (combinational, same cycle):
  - W_raw = W_NOM + (sign-extended v_k <<< 1), computed in NCO_WIDTH+2 signed bits.
  - W = clamp(W_raw, W_MIN, W_MAX).
  - v_k is used as present at the clock edge; a v_k change in the same cycle as sample_valid takes effect on that sample.
- NCO update, only when sample_valid=1:
  - diff = {1'b0, eta} − {1'b0, W}, NCO_WIDTH+1 bits.
  - Borrow (diff MSB = 1) means underflow:
    - eta ← diff[NCO_WIDTH-1:0], which implicitly adds 1.0.
    - strobe ← 1.
    - mu ← min(eta_prev << 1, all-ones), where eta_prev is the pre-decrement eta. This is the eta/W approximation for W ≈ 0.5.
  - No borrow: eta ← diff[NCO_WIDTH-1:0], strobe ← 0, mu holds its previous value.
- sample_valid=0:
  - eta, mu, i_out and q_out hold.
  - strobe ← 0 and out_valid ← 0. strobe is never asserted without out_valid.
- Latency: 1 cycle from sample_valid to out_valid/strobe/mu/i_out/q_out. All outputs are registered.
- Boundary cases:
  - eta exactly equal to W gives diff = 0, with no strobe.
  - eta_prev ≥ 0x8000 saturates mu to 0xFFFF.
  - W is never 0 (guaranteed by the clamp), so the NCO always progresses.
  - Back-to-back sample_valid every cycle is supported with no bubbles.

Decomposition:
- Shared package zcted_pkg:
  - DATA_WIDTH and NCO_WIDTH.
  - Q-format constants: ONE_Q016 = 17'h10000, W_NOM, W_MIN, W_MAX.
  - Q1.15 → Q0.16 scale-shift constant.
  - These are shared with the loop filter and the interpolator.
- One natural combinational sub-module, zcted_w_sat: v_k → clamped W. It is reused by any future loop-gain probe logic.
- The NCO register, mu generation and the data delay stay in the top module.

Test Plan:
1. Reset/idle: hold rst_n=0, then release with sample_valid=0 -> all outputs 0, eta=0x0000, unchanged for 20 cycles.
2. Nominal rate: v_k=0, sample_valid continuous -> eta sequence 0x8000, 0x0000, 0x8000, ...; strobe on every other sample starting with the first; mu=0x0000.
3. Offset: v_k=+0x0800 (W=0x9000), from reset -> eta 0x7000 (strobe, mu 0x0000), 0xE000 (strobe, mu 0xE000), 0x5000 (no strobe), 0xC000 (strobe, mu 0xA000).
4. Clamping:
   - v_k=0x7FFF -> W=0xC000; from eta=0 the next eta=0x4000 with strobe.
   - v_k=0x8000 -> W=0x4000; eta=0xC000 with strobe.
5. Gapped input: sample_valid pattern 1,0,0,1 with v_k=0 -> eta frozen during gaps, strobe/out_valid low in gap cycles, i_out/q_out hold the last valid sample.
6. Reset mid-stream: assert rst_n=0 between two strobes for 1 cycle, asynchronously -> outputs clear immediately; the post-release sequence matches scenario 2 exactly.

Source files
------------

// File: rtl/zcted_pkg.sv
// Shared Q-format constants for the ZCTED timing loop (loop filter, NCO, interpolator).
package zcted_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int NCO_WIDTH  = 16;

  localparam logic [16:0] ONE_Q016 = 17'h10000;
  localparam logic [15:0] W_NOM    = 16'h8000;
  localparam logic [15:0] W_MIN    = 16'h4000;
  localparam logic [15:0] W_MAX    = 16'hC000;

  // Left shift that turns a Q1.15 control word into Q0.16 step units
  localparam int Q15_TO_Q16_SHIFT = 1;
endpackage

// File: rtl/zcted_w_sat.sv
// Maps the loop-filter control word v_k to the clamped NCO step W = clamp(W_NOM + 2*v_k).
module zcted_w_sat
  import zcted_pkg::*;
#(
  parameter int                    DATA_WIDTH = zcted_pkg::DATA_WIDTH,
  parameter int                    NCO_WIDTH  = zcted_pkg::NCO_WIDTH,
  parameter logic [NCO_WIDTH-1:0]  W_NOM      = zcted_pkg::W_NOM,
  parameter logic [NCO_WIDTH-1:0]  W_MIN      = zcted_pkg::W_MIN,
  parameter logic [NCO_WIDTH-1:0]  W_MAX      = zcted_pkg::W_MAX
) (
  input  logic signed [DATA_WIDTH-1:0] v_k,
  output logic        [NCO_WIDTH-1:0]  w
);

  localparam int SW = NCO_WIDTH + 2;

  function automatic logic [NCO_WIDTH-1:0] clamp_w(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] lo;
    logic signed [SW-1:0] hi;
    lo = signed'({2'b00, W_MIN});
    hi = signed'({2'b00, W_MAX});
    if (x < lo)
      clamp_w = W_MIN;
    else if (x > hi)
      clamp_w = W_MAX;
    else
      clamp_w = x[NCO_WIDTH-1:0];
  endfunction

  logic signed [SW-1:0] v_ext;
  logic signed [SW-1:0] w_raw;

  always_comb begin
    v_ext = SW'(v_k);
    w_raw = signed'({2'b00, W_NOM}) + (v_ext <<< Q15_TO_Q16_SHIFT);
    w     = clamp_w(w_raw);
  end

endmodule

// File: rtl/zcted_interp_ctrl_nco.sv
// Modulo-1 decrementing NCO: emits strobe and fractional interval mu on underflow,
// with the I/Q samples delayed one cycle so they line up with strobe/mu.
module zcted_interp_ctrl_nco
  import zcted_pkg::*;
#(
  parameter int                    DATA_WIDTH = zcted_pkg::DATA_WIDTH,
  parameter int                    NCO_WIDTH  = zcted_pkg::NCO_WIDTH,
  parameter logic [NCO_WIDTH-1:0]  W_NOM      = zcted_pkg::W_NOM,
  parameter logic [NCO_WIDTH-1:0]  W_MIN      = zcted_pkg::W_MIN,
  parameter logic [NCO_WIDTH-1:0]  W_MAX      = zcted_pkg::W_MAX,
  parameter logic [NCO_WIDTH-1:0]  ETA_INIT   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] q_in,
  input  logic signed [DATA_WIDTH-1:0] v_k,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] q_out,
  output logic                         strobe,
  output logic        [NCO_WIDTH-1:0]  mu,
  output logic        [NCO_WIDTH-1:0]  eta
);

  // mu ~= eta/W with W ~= 0.5, i.e. 2*eta, saturated just below 1.0
  function automatic logic [NCO_WIDTH-1:0] sat_mu(input logic [NCO_WIDTH-1:0] eta_prev);
    logic [NCO_WIDTH:0] dbl;
    dbl = {eta_prev, 1'b0};
    if (dbl >= ONE_Q016)
      sat_mu = '1;
    else
      sat_mu = dbl[NCO_WIDTH-1:0];
  endfunction

  logic        [NCO_WIDTH-1:0]  w_p0;
  logic        [NCO_WIDTH:0]    diff_p0;
  logic                         borrow_p0;

  logic                         vld_p1;
  logic                         strobe_p1;
  logic        [NCO_WIDTH-1:0]  eta_p1;
  logic        [NCO_WIDTH-1:0]  mu_p1;
  logic signed [DATA_WIDTH-1:0] i_p1;
  logic signed [DATA_WIDTH-1:0] q_p1;

  // Stage p0: step and underflow detection, combinational on the current sample
  zcted_w_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .NCO_WIDTH  (NCO_WIDTH),
    .W_NOM      (W_NOM),
    .W_MIN      (W_MIN),
    .W_MAX      (W_MAX)
  ) u_w_sat (
    .v_k (v_k),
    .w   (w_p0)
  );

  always_comb begin
    diff_p0   = {1'b0, eta_p1} - {1'b0, w_p0};
    borrow_p0 = diff_p0[NCO_WIDTH];
  end

  // Stage p1: NCO register, strobe/mu and aligned sample delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      strobe_p1 <= 1'b0;
      eta_p1    <= ETA_INIT;
      mu_p1     <= '0;
      i_p1      <= '0;
      q_p1      <= '0;
    end else begin
      vld_p1    <= sample_valid;
      strobe_p1 <= sample_valid & borrow_p0;
      if (sample_valid) begin
        eta_p1 <= diff_p0[NCO_WIDTH-1:0];
        i_p1   <= i_in;
        q_p1   <= q_in;
        if (borrow_p0)
          mu_p1 <= sat_mu(eta_p1);
      end
    end
  end

  assign out_valid = vld_p1;
  assign strobe    = strobe_p1;
  assign eta       = eta_p1;
  assign mu        = mu_p1;
  assign i_out     = i_p1;
  assign q_out     = q_p1;

endmodule

// File: tb/tb_zcted_interp_ctrl_nco.sv
// Directed bench for zcted_interp_ctrl_nco: behavioural NCO model checked every cycle,
// plus hand-computed literal eta/strobe/mu sequences.
module tb_zcted_interp_ctrl_nco;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] i_in = '0;
  logic [15:0] q_in = '0;
  logic [15:0] v_k = '0;
  logic        out_valid;
  logic [15:0] i_out;
  logic [15:0] q_out;
  logic        strobe;
  logic [15:0] mu;
  logic [15:0] eta;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  zcted_interp_ctrl_nco dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .i_in         (i_in),
    .q_in         (q_in),
    .v_k          (v_k),
    .out_valid    (out_valid),
    .i_out        (i_out),
    .q_out        (q_out),
    .strobe       (strobe),
    .mu           (mu),
    .eta          (eta)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: eta as an integer phase in [0,65536)
  int m_eta, m_mu, m_i, m_q;
  bit m_vld, m_strobe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_eta = 0; m_mu = 0; m_i = 0; m_q = 0; m_vld = 0; m_strobe = 0;
    end else begin
      int w;
      m_vld = sample_valid;
      m_strobe = 0;
      if (sample_valid) begin
        w = 32768 + 2 * int'($signed(v_k));
        if (w < 16384) w = 16384;
        if (w > 49152) w = 49152;
        if (m_eta < w) begin
          m_strobe = 1;
          m_mu = (2 * m_eta > 65535) ? 65535 : 2 * m_eta;
          m_eta = m_eta - w + 65536;
        end else begin
          m_eta = m_eta - w;
        end
        m_i = int'(i_in);
        m_q = int'(q_in);
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(m_vld));
    chk("strobe", int'(strobe), int'(m_strobe));
    chk("eta", int'(eta), m_eta);
    chk("mu", int'(mu), m_mu);
    chk("i_out", int'(i_out), m_i);
    chk("q_out", int'(q_out), m_q);
    if (strobe && !out_valid) chk("strobe_without_valid", 1, 0);
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drive(input bit v, input logic [15:0] vk, input logic [15:0] i, input logic [15:0] q);
    @(negedge clk);
    sample_valid = v;
    v_k = vk;
    i_in = i;
    q_in = q;
  endtask

  // Drive one cycle and pin the registered result to literal values
  task automatic samp(input string nm, input bit v, input logic [15:0] vk,
                      input int e_eta, input int e_strobe, input int e_mu);
    drive(v, vk, 16'(total), 16'(~total));
    @(posedge clk);
    #1;
    chk({nm, ".eta"}, int'(eta), e_eta);
    chk({nm, ".strobe"}, int'(strobe), e_strobe);
    chk({nm, ".mu"}, int'(mu), e_mu);
    chk({nm, ".out_valid"}, int'(out_valid), int'(v));
  endtask

  initial begin
    logic [15:0] vk_tbl [8];
    vk_tbl = '{16'h0000, 16'h0800, 16'hF800, 16'h7FFF, 16'h8000, 16'h2000, 16'hE000, 16'h1234};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1: idle after reset
    repeat (20) @(negedge clk);
    chk("idle.eta", int'(eta), 0);
    chk("idle.out_valid", int'(out_valid), 0);

    // 2: nominal rate, eta == W case on every second sample
    do_reset();
    samp("nom0", 1, 16'h0000, 16'h8000, 1, 0);
    samp("nom1", 1, 16'h0000, 16'h0000, 0, 0);
    samp("nom2", 1, 16'h0000, 16'h8000, 1, 0);
    samp("nom3", 1, 16'h0000, 16'h0000, 0, 0);

    // 3: positive offset, W = 0x9000
    do_reset();
    samp("off0", 1, 16'h0800, 16'h7000, 1, 16'h0000);
    samp("off1", 1, 16'h0800, 16'hE000, 1, 16'hE000);
    samp("off2", 1, 16'h0800, 16'h5000, 0, 16'hE000);
    samp("off3", 1, 16'h0800, 16'hC000, 1, 16'hA000);

    // 4: clamp high (W = 0xC000), including mu saturation
    do_reset();
    samp("chi0", 1, 16'h7FFF, 16'h4000, 1, 16'h0000);
    samp("chi1", 1, 16'h7FFF, 16'h8000, 1, 16'h8000);
    samp("chi2", 1, 16'h7FFF, 16'hC000, 1, 16'hFFFF);
    // clamp low (W = 0x4000)
    do_reset();
    samp("clo0", 1, 16'h8000, 16'hC000, 1, 16'h0000);
    samp("clo1", 1, 16'h8000, 16'h8000, 0, 16'h0000);

    // 5: gapped input 1,0,0,1
    do_reset();
    drive(1, 16'h0000, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    chk("gap.i_first", int'(i_out), 16'h1111);
    drive(0, 16'h0000, 16'h3333, 16'h4444);
    @(posedge clk); #1;
    chk("gap.eta_hold", int'(eta), 16'h8000);
    chk("gap.strobe_low", int'(strobe), 0);
    chk("gap.i_hold", int'(i_out), 16'h1111);
    chk("gap.q_hold", int'(q_out), 16'h2222);
    drive(0, 16'h0000, 16'h5555, 16'h6666);
    drive(1, 16'h0000, 16'h7777, 16'h8888);
    @(posedge clk); #1;
    chk("gap.eta_after", int'(eta), 16'h0000);
    chk("gap.i_after", int'(i_out), 16'h7777);

    // 6: asynchronous reset between strobes
    do_reset();
    samp("mid0", 1, 16'h0000, 16'h8000, 1, 0);
    samp("mid1", 1, 16'h0000, 16'h0000, 0, 0);
    samp("mid2", 1, 16'h0000, 16'h8000, 1, 0);
    #1 rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    chk("mid.rst_eta", int'(eta), 0);
    chk("mid.rst_strobe", int'(strobe), 0);
    chk("mid.rst_valid", int'(out_valid), 0);
    chk("mid.rst_i", int'(i_out), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    samp("post0", 1, 16'h0000, 16'h8000, 1, 0);
    samp("post1", 1, 16'h0000, 16'h0000, 0, 0);
    samp("post2", 1, 16'h0000, 16'h8000, 1, 0);

    // Mixed directed control words and gaps, checked by the model only
    for (int k = 0; k < 48; k++)
      drive((k % 5) != 2, vk_tbl[k % 8], 16'(k * 16'h0101), 16'(16'hF000 - k));
    drive(0, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
